// File: rtl/csr_commit_unit.sv
// csr_commit_unit
//   Executes one CSR instruction at the commit head as a three-cycle
//   sequence:
//     IDLE : accept and latch the operands
//     EXEC : read the old value, form the new value, decide legality
//     RESP : report the result and perform the write
//   It also hosts the machine-mode CSRs and the mcycle/minstret counters.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   flush_i        abort the in-flight op (no write, no result pulse)
//   commit_valid_i CSR instruction present at commit head
//   commit_ready_o unit idle and able to accept an op
//   csr_addr_i     CSR address (12 bits)
//   csr_op_i       00 RW, 01 RS, 10 RC, 11 read-only
//   csr_wdata_i    source operand
//   wr_suppress_i  rs1/uimm is zero: RS/RC do not write
//   instret_i      one instruction retired this cycle
//   csr_commit_o   one-cycle pulse releasing the issue-side address buffer
//   csr_valid_o    one-cycle result strobe
//   csr_rdata_o    old CSR value (0 when illegal or not valid)
//   illegal_o      op faulted, qualified by csr_valid_o
module csr_commit_unit #(
  parameter int XLEN    = 64,
  parameter int HART_ID = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            commit_valid_i,
  output logic            commit_ready_o,
  input  logic [11:0]     csr_addr_i,
  input  logic [1:0]      csr_op_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            wr_suppress_i,
  input  logic            instret_i,
  output logic            csr_commit_o,
  output logic            csr_valid_o,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            illegal_o
);

  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [11:0]     addr_p0;
  logic [1:0]      op_p0;
  logic [XLEN-1:0] wdata_p0;
  logic            supp_p0;

  logic [XLEN-1:0] old_p1;
  logic [XLEN-1:0] new_p1;
  logic            ill_p1;

  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mcycle_q, minstret_q;

  logic            accept;
  logic            resp_live;
  logic            wr_attempt;
  logic            csr_we;
  logic            impl;
  logic            ill_d;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] new_val;

  assign accept         = (state_q == IDLE) && commit_valid_i && !flush_i;
  assign resp_live      = (state_q == RESP) && !flush_i;
  // RW always writes; RS/RC write unless the source is x0 / uimm 0.
  assign wr_attempt     = (op_p0 == 2'b00) || ((op_p0 != 2'b11) && !supp_p0);
  assign csr_we         = resp_live && !ill_p1 && wr_attempt;

  assign commit_ready_o = (state_q == IDLE);
  assign csr_valid_o    = resp_live;
  assign csr_commit_o   = resp_live;
  assign csr_rdata_o    = (resp_live && !ill_p1) ? old_p1 : '0;
  assign illegal_o      = resp_live && ill_p1;

  always_comb begin
    rd_val = '0;
    impl   = 1'b1;
    case (addr_p0)
      ADDR_MTVEC:    rd_val = mtvec_q;
      ADDR_MSCRATCH: rd_val = mscratch_q;
      ADDR_MEPC:     rd_val = mepc_q;
      ADDR_MCAUSE:   rd_val = mcause_q;
      ADDR_MCYCLE:   rd_val = mcycle_q;
      ADDR_MINSTRET: rd_val = minstret_q;
      ADDR_MHARTID:  rd_val = XLEN'(HART_ID);
      default:       impl   = 1'b0;
    endcase
    ill_d = !impl || (wr_attempt && (addr_p0[11:10] == 2'b11));
    case (op_p0)
      2'b00:   new_val = wdata_p0;
      2'b01:   new_val = rd_val | wdata_p0;
      2'b10:   new_val = rd_val & ~wdata_p0;
      default: new_val = rd_val;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (commit_valid_i) state_d = EXEC;
        EXEC:    state_d = RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // stage p0: operands captured on acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_p0  <= '0;
      op_p0    <= '0;
      wdata_p0 <= '0;
      supp_p0  <= 1'b0;
    end else if (accept) begin
      addr_p0  <= csr_addr_i;
      op_p0    <= csr_op_i;
      wdata_p0 <= csr_wdata_i;
      supp_p0  <= wr_suppress_i;
    end
  end

  // stage p1: old value, new value and legality registered in EXEC
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      old_p1 <= '0;
      new_p1 <= '0;
      ill_p1 <= 1'b0;
    end else if (state_q == EXEC) begin
      old_p1 <= rd_val;
      new_p1 <= new_val;
      ill_p1 <= ill_d;
    end
  end

  // CSR file: written in RESP; counter writes beat the same-cycle increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_we && addr_p0 == ADDR_MTVEC)    mtvec_q    <= {new_p1[XLEN-1:2], 1'b0, new_p1[0]};
      if (csr_we && addr_p0 == ADDR_MSCRATCH) mscratch_q <= new_p1;
      if (csr_we && addr_p0 == ADDR_MEPC)     mepc_q     <= {new_p1[XLEN-1:2], 2'b00};
      if (csr_we && addr_p0 == ADDR_MCAUSE)   mcause_q   <= new_p1;
      if (csr_we && addr_p0 == ADDR_MCYCLE)   mcycle_q   <= new_p1;
      else                                    mcycle_q   <= mcycle_q + XLEN'(1);
      if (csr_we && addr_p0 == ADDR_MINSTRET) minstret_q <= new_p1;
      else if (instret_i)                     minstret_q <= minstret_q + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_csr_commit_unit.sv
// tb_csr_commit_unit
//   Directed-vector bench for csr_commit_unit (XLEN 64, HART_ID 5).
//   Inputs change 1ns after the rising edge; outputs are sampled on the
//   falling edge.
module tb_csr_commit_unit;
  localparam int XLEN = 64;
  localparam int HART = 5;
  localparam logic [XLEN-1:0] ONES = '1;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            commit_valid_i;
  logic            commit_ready_o;
  logic [11:0]     csr_addr_i;
  logic [1:0]      csr_op_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic            wr_suppress_i;
  logic            instret_i;
  logic            csr_commit_o;
  logic            csr_valid_o;
  logic [XLEN-1:0] csr_rdata_o;
  logic            illegal_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [XLEN-1:0] rd;
  logic            ill;

  always #5 clk_i = ~clk_i;

  csr_commit_unit #(.XLEN(XLEN), .HART_ID(HART)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .commit_valid_i (commit_valid_i),
    .commit_ready_o (commit_ready_o),
    .csr_addr_i     (csr_addr_i),
    .csr_op_i       (csr_op_i),
    .csr_wdata_i    (csr_wdata_i),
    .wr_suppress_i  (wr_suppress_i),
    .instret_i      (instret_i),
    .csr_commit_o   (csr_commit_o),
    .csr_valid_o    (csr_valid_o),
    .csr_rdata_o    (csr_rdata_o),
    .illegal_o      (illegal_o)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called 1ns after a rising edge with the unit idle. Accept edge is cycle N;
  // EXEC in N+1 shows no strobe, RESP in N+2 carries the result.
  task automatic do_op(input string tag, input logic [11:0] a, input logic [1:0] op,
                       input logic [XLEN-1:0] wd, input logic supp,
                       output logic [XLEN-1:0] rdata, output logic illg);
    chk({tag, "_ready"}, XLEN'(commit_ready_o), 1);
    csr_addr_i     = a;
    csr_op_i       = op;
    csr_wdata_i    = wd;
    wr_suppress_i  = supp;
    commit_valid_i = 1'b1;
    @(posedge clk_i); #1;
    commit_valid_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_exec_valid"}, XLEN'(csr_valid_o), 0);
    chk({tag, "_exec_rdata"}, csr_rdata_o, 0);
    @(negedge clk_i);
    chk({tag, "_valid"}, XLEN'(csr_valid_o), 1);
    chk({tag, "_commit"}, XLEN'(csr_commit_o), 1);
    rdata = csr_rdata_o;
    illg  = illegal_o;
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; commit_valid_i = 1'b0; csr_addr_i = '0;
    csr_op_i = '0; csr_wdata_i = '0; wr_suppress_i = 1'b0; instret_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready",  XLEN'(commit_ready_o), 1);
    chk("rst_valid",  XLEN'(csr_valid_o), 0);
    chk("rst_commit", XLEN'(csr_commit_o), 0);
    chk("rst_ill",    XLEN'(illegal_o), 0);
    chk("rst_rdata",  csr_rdata_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // mscratch RW then RS
    do_op("rw340", 12'h340, 2'b00, 64'hDEAD, 1'b0, rd, ill);
    chk("rw340_rdata", rd, 0);
    chk("rw340_ill", XLEN'(ill), 0);
    do_op("rs340", 12'h340, 2'b01, 64'h0F00, 1'b0, rd, ill);
    chk("rs340_rdata", rd, 64'hDEAD);
    do_op("rd340", 12'h340, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("rd340_rdata", rd, 64'hDFAD);

    // mepc alignment and RC
    do_op("rw341", 12'h341, 2'b00, 64'h1003, 1'b0, rd, ill);
    do_op("rd341a", 12'h341, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("mepc_align", rd, 64'h1000);
    do_op("rc341", 12'h341, 2'b10, 64'h1000, 1'b0, rd, ill);
    chk("rc341_rdata", rd, 64'h1000);
    do_op("rd341b", 12'h341, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("mepc_clear", rd, 0);

    // mtvec bit 1 forced low, mcause plain
    do_op("rw305", 12'h305, 2'b00, 64'hFFF, 1'b0, rd, ill);
    do_op("rd305", 12'h305, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("mtvec_mask", rd, 64'hFFD);
    do_op("rw342", 12'h342, 2'b00, 64'h8000_0000_0000_000B, 1'b0, rd, ill);
    do_op("rd342", 12'h342, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("mcause_rb", rd, 64'h8000_0000_0000_000B);

    // mhartid write illegal, suppressed RS legal
    do_op("rwF14", 12'hF14, 2'b00, 64'h1, 1'b0, rd, ill);
    chk("rwF14_ill", XLEN'(ill), 1);
    chk("rwF14_rdata", rd, 0);
    do_op("rsF14", 12'hF14, 2'b01, 64'h0, 1'b1, rd, ill);
    chk("rsF14_ill", XLEN'(ill), 0);
    chk("rsF14_rdata", rd, XLEN'(HART));

    // unimplemented addresses
    do_op("rw7C0", 12'h7C0, 2'b00, 64'h1234, 1'b0, rd, ill);
    chk("rw7C0_ill", XLEN'(ill), 1);
    chk("rw7C0_rdata", rd, 0);
    do_op("rdC00", 12'hC00, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("rdC00_ill", XLEN'(ill), 1);
    do_op("rd340c", 12'h340, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("after_ill_mscratch", rd, 64'hDFAD);

    // flush in EXEC
    csr_addr_i = 12'h340; csr_op_i = 2'b00; csr_wdata_i = 64'h5; wr_suppress_i = 1'b0;
    commit_valid_i = 1'b1;
    @(posedge clk_i); #1;
    commit_valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    chk("flexec_valid", XLEN'(csr_valid_o), 0);
    chk("flexec_commit", XLEN'(csr_commit_o), 0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flexec_ready", XLEN'(commit_ready_o), 1);
    chk("flexec_valid2", XLEN'(csr_valid_o), 0);
    @(posedge clk_i); #1;
    do_op("rd340d", 12'h340, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("flexec_mscratch", rd, 64'hDFAD);

    // flush in RESP
    csr_addr_i = 12'h340; csr_op_i = 2'b00; csr_wdata_i = 64'h9; commit_valid_i = 1'b1;
    @(posedge clk_i); #1;
    commit_valid_i = 1'b0;
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flresp_valid", XLEN'(csr_valid_o), 0);
    chk("flresp_commit", XLEN'(csr_commit_o), 0);
    chk("flresp_rdata", csr_rdata_o, 0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    do_op("rd340e", 12'h340, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("flresp_mscratch", rd, 64'hDFAD);

    // commit_valid ignored while flushing
    flush_i = 1'b1; commit_valid_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; commit_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flidle_ready", XLEN'(commit_ready_o), 1);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("flidle_valid", XLEN'(csr_valid_o), 0);
    @(posedge clk_i); #1;

    // mcycle write wins over increment, then wraps to 0
    do_op("rwB00", 12'hB00, 2'b00, ONES, 1'b0, rd, ill);
    do_op("rdB00", 12'hB00, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("mcycle_wrap", rd, 0);

    // minstret counting, write priority, wrap
    instret_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    instret_i = 1'b0;
    do_op("rdB02a", 12'hB02, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("minstret_cnt", rd, 64'd3);
    instret_i = 1'b1;
    do_op("rwB02", 12'hB02, 2'b00, ONES, 1'b0, rd, ill);
    chk("rwB02_old", rd, 64'd4);
    instret_i = 1'b0;
    do_op("rdB02b", 12'hB02, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("minstret_wr_wins", rd, ONES);
    instret_i = 1'b1;
    @(posedge clk_i); #1;
    instret_i = 1'b0;
    do_op("rdB02c", 12'hB02, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("minstret_wrap", rd, 0);

    // reset during an op: no pulse, state cleared
    csr_addr_i = 12'h340; csr_op_i = 2'b00; csr_wdata_i = 64'h77; commit_valid_i = 1'b1;
    @(posedge clk_i); #1;
    commit_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("midrst_ready", XLEN'(commit_ready_o), 1);
    chk("midrst_valid", XLEN'(csr_valid_o), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("midrst_valid2", XLEN'(csr_valid_o), 0);
    chk("midrst_commit", XLEN'(csr_commit_o), 0);
    @(posedge clk_i); #1;
    do_op("rd340f", 12'h340, 2'b11, 64'h0, 1'b0, rd, ill);
    chk("midrst_mscratch", rd, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/csr_commit_unit.md
CSR_COMMIT_UNIT -- requirements
Module: csr_commit_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  abort the in-flight CSR op.
REQ-006 SHALL have port commit_valid_i  input  1  CSR instruction at commit head.
REQ-007 SHALL have port commit_ready_o  output  1  unit can accept an op.
REQ-008 SHALL have port csr_addr_i  input  12  CSR address from the issue-side CSR address buffer.
REQ-009 SHALL have port csr_op_i  input  2  00 RW, 01 RS, 10 RC, 11 read-only.
REQ-010 SHALL have port csr_wdata_i  input  XLEN  source operand.
REQ-011 SHALL have port wr_suppress_i  input  1  rs1/uimm is x0/0; no write for RS/RC.
REQ-012 SHALL have port instret_i  input  1  one instruction retired this cycle.
REQ-013 SHALL have port csr_commit_o  output  1  one-cycle pulse releasing the issue-side address buffer.
REQ-014 SHALL have port csr_valid_o  output  1  result valid, one cycle.
REQ-015 SHALL have port csr_rdata_o  output  XLEN  old CSR value.
REQ-016 SHALL have port illegal_o  output  1  op faulted; qualified by csr_valid_o.

Function
REQ-017 SHALL implement these CSRs: mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mhartid 0xF14 (read-only, HART_ID).
REQ-018 SHALL force mepc[1:0]=0 and mtvec[1]=0 on every write.
REQ-019 SHALL use FSM states IDLE, EXEC, RESP; IDLE->EXEC on commit_valid_i; EXEC->RESP unconditionally; RESP->IDLE unconditionally.
REQ-020 SHALL drive commit_ready_o high only in IDLE; commit_valid_i is ignored outside IDLE.
REQ-021 SHALL latch addr, op, wdata and wr_suppress_i on IDLE acceptance.
REQ-022 SHALL, in EXEC, register old value, new value (RW: wdata; RS: old|wdata; RC: old&~wdata) and the illegal flag.
REQ-023 SHALL flag illegal for an unimplemented address, or a write attempt (RW, or RS/RC without suppress) to addr[11:10]==2'b11.
REQ-024 SHALL, in RESP, pulse csr_valid_o and csr_commit_o, drive csr_rdata_o (0 if illegal) and illegal_o.
REQ-025 SHALL update the CSR in RESP only if not illegal, op is not 11, and RS/RC is not suppressed.
REQ-026 SHALL give a latency of accept cycle N -> csr_valid_o in cycle N+2; throughput one op per 3 cycles.
REQ-027 SHALL increment mcycle every cycle and minstret on instret_i, both wrapping 2^XLEN-1 -> 0.
REQ-028 SHALL give a same-cycle CSR write to mcycle/minstret priority over its increment.
REQ-029 SHALL, on flush_i in any state, go to IDLE next cycle, suppress the CSR write and suppress csr_valid_o/csr_commit_o that cycle.
REQ-030 SHALL ignore commit_valid_i in a cycle where flush_i is high.
REQ-031 SHALL hold csr_rdata_o and illegal_o at 0 when csr_valid_o is low.

Reset
REQ-032 SHALL, on rst_ni low, asynchronously enter IDLE and clear all CSRs, counters and latched operands to 0.
REQ-033 SHALL hold reset output values csr_valid_o=0, csr_commit_o=0, illegal_o=0, csr_rdata_o=0, commit_ready_o=1.
REQ-034 SHALL, when reset asserts mid-operation, perform no CSR write and emit no pulse.

Verification
REQ-035 Bench SHALL cover: RW 0x340 wdata 0xDEAD, then RS 0x340 wdata 0x0F00 -> second rdata 0xDEAD, mscratch becomes 0xDFAD, valid at N+2.
REQ-036 Bench SHALL cover: RW 0x341 wdata 0x1003 -> mepc reads back 0x1000; RC 0x341 wdata 0x1000 -> mepc 0.
REQ-037 Bench SHALL cover: RW 0xF14 -> illegal_o=1, rdata 0; RS 0xF14 with wr_suppress_i=1 -> legal, rdata HART_ID.
REQ-038 Bench SHALL cover: address 0x7C0 -> illegal_o=1 and no CSR state change.
REQ-039 Bench SHALL cover: flush_i in EXEC of RW 0x340 wdata 5 -> no csr_valid_o/csr_commit_o, mscratch unchanged, commit_ready_o=1 next cycle.
REQ-040 Bench SHALL cover: RW 0xB00 wdata 2^XLEN-1 -> mcycle reads 0 two cycles later (wrap), with RW winning over the same-cycle increment.
